// File: rtl/memory_controller_if.sv
// Address/control side of the nnARM external bus.
// Handshake: the master holds AddressBus/nRW/nBW/nMREQ/SEQ stable for the
// whole access. The access completes on the rising MCLK edge at which
// nWAIT is 1. While nWAIT is 0 the access is stretched and the master must
// not change its signals. DataBus is bidirectional and stays a plain port on
// the memory so that its tristate driver is kept out of the interface.
interface memory_controller_if;
  logic [31:0] AddressBus;
  logic        nRW;
  logic        nBW;
  logic        nMREQ;
  logic        SEQ;
  logic        nWAIT;

  modport master (
    output AddressBus, nRW, nBW, nMREQ, SEQ,
    input  nWAIT
  );

  modport slave (
    input  AddressBus, nRW, nBW, nMREQ, SEQ,
    output nWAIT
  );
endinterface

// File: rtl/memory_controller.sv
// Byte-addressed little-endian main memory with wait-state insertion.
// Reads drive DataBus combinationally for the whole access. Writes commit on
// the completing edge. Memory contents survive reset.
module memory_controller #(
  parameter int MEM_SIZE  = 131072,
  parameter int NSEQ_WAIT = 1,
  parameter int SEQ_WAIT  = 0
) (
  input  logic                 MCLK,
  input  logic                 nRESET,
  inout  wire  [31:0]          DataBus,
  memory_controller_if.slave   bus,
  output logic                 dbg_state_o
);

  localparam int AW = $clog2(MEM_SIZE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] req_wait;
  logic       nwait_c;
  logic       rd_en;
  logic       wr_commit;
  logic [AW-1:0] byte_a;
  logic [AW-1:0] word_a;
  logic [31:0]   rdata;

  logic [7:0] Memory [0:MEM_SIZE-1];

  // Upper address bits wrap modulo the memory size; word accesses ignore bits [1:0].
  assign byte_a   = AW'(bus.AddressBus % 32'(MEM_SIZE));
  assign word_a   = {byte_a[AW-1:2], 2'b00};
  assign req_wait = bus.SEQ ? 4'(SEQ_WAIT) : 4'(NSEQ_WAIT);

  // Read data: little-endian word, or the addressed byte replicated on all lanes.
  always_comb begin
    rdata = {4{Memory[byte_a]}};
    if (bus.nBW) begin
      rdata = {Memory[word_a + AW'(3)], Memory[word_a + AW'(2)],
               Memory[word_a + AW'(1)], Memory[word_a]};
    end
  end

  assign rd_en   = nRESET && !bus.nMREQ && !bus.nRW;
  assign DataBus = rd_en ? rdata : 32'hzzzzzzzz;

  // Wait-state sequencing: IDLE decides combinationally, WAIT counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nwait_c = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!bus.nMREQ && (req_wait != 4'd0)) begin
          nwait_c = 1'b0;
          state_d = ST_WAIT;
          cnt_d   = req_wait - 4'd1;
        end
      end
      ST_WAIT: begin
        if (bus.nMREQ) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          nwait_c = 1'b0;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // A reset abandons any access immediately.
    if (!nRESET) nwait_c = 1'b1;
  end

  // State and wait counter registers.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_commit   = !bus.nMREQ && bus.nRW && nwait_c;
  assign bus.nWAIT   = nwait_c;
  assign dbg_state_o = state_q;

  // Memory array update on the completing edge of a write; never reset.
  always_ff @(posedge MCLK) begin
    if (nRESET && wr_commit) begin
      if (bus.nBW) begin
        Memory[word_a]          <= DataBus[7:0];
        Memory[word_a + AW'(1)] <= DataBus[15:8];
        Memory[word_a + AW'(2)] <= DataBus[23:16];
        Memory[word_a + AW'(3)] <= DataBus[31:24];
      end else begin
        Memory[byte_a] <= DataBus[7:0];
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed scenarios plus randomized accesses
// checked against a byte-level memory model and wait-count rule.
module tb_memory_controller;

  localparam int MEM_SIZE  = 131072;
  localparam int NSEQ_WAIT = 1;
  localparam int SEQ_WAIT  = 0;

  logic        MCLK;
  logic        nRESET;
  wire  [31:0] DataBus;
  logic        drv_en;
  logic [31:0] drv_data;
  logic        dbg_state;

  int total;
  int bad;

  logic [7:0] mdl [int];

  memory_controller_if bus ();

  memory_controller #(
    .MEM_SIZE (MEM_SIZE),
    .NSEQ_WAIT(NSEQ_WAIT),
    .SEQ_WAIT (SEQ_WAIT)
  ) dut (
    .MCLK       (MCLK),
    .nRESET     (nRESET),
    .DataBus    (DataBus),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  assign DataBus = drv_en ? drv_data : 32'hzzzzzzzz;

  // Clock / reset block
  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // ---------------- reference model ----------------
  function automatic int eff_addr(input logic [31:0] a);
    return int'(a % 32'(MEM_SIZE));
  endfunction

  function automatic logic [7:0] mb(input int a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input logic bw, input logic [31:0] addr);
    int a;
    a = eff_addr(addr);
    if (bw) begin
      a = a - (a % 4);
      return {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
    end
    return {4{mb(a)}};
  endfunction

  task automatic model_write(input logic bw, input logic [31:0] addr, input logic [31:0] d);
    int a;
    a = eff_addr(addr);
    if (bw) begin
      a = a - (a % 4);
      mdl[a]     = d[7:0];
      mdl[a + 1] = d[15:8];
      mdl[a + 2] = d[23:16];
      mdl[a + 3] = d[31:24];
    end else begin
      mdl[a] = d[7:0];
    end
  endtask

  function automatic int exp_waits(input logic seq);
    return seq ? SEQ_WAIT : NSEQ_WAIT;
  endfunction

  task automatic preload(input int a, input logic [7:0] v);
    dut.Memory[a] = v;
    mdl[a] = v;
  endtask

  // ---------------- driver ----------------
  task automatic bus_access(input logic seq, input logic rw, input logic bw,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int waits, output logic [31:0] first_data,
                            output logic [31:0] rdata);
    @(negedge MCLK);
    bus.AddressBus = addr;
    bus.nRW        = rw;
    bus.nBW        = bw;
    bus.SEQ        = seq;
    bus.nMREQ      = 1'b0;
    drv_en         = rw;
    drv_data       = wdata;
    waits          = 0;
    #1;
    first_data = DataBus;
    while (bus.nWAIT !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge MCLK);
      #1;
    end
    if (waits >= 40) begin
      total++;
      bad++;
      $display("FAIL timeout: nWAIT stuck low at addr %h", addr);
    end
    rdata = DataBus;
    @(posedge MCLK);
    #1;
    bus.nMREQ = 1'b1;
    drv_en    = 1'b0;
    if (rw) model_write(bw, addr, wdata);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRESET = 1'b0;
    bus.AddressBus = 32'h0;
    bus.nRW = 1'b0;
    bus.nBW = 1'b1;
    bus.SEQ = 1'b0;
    bus.nMREQ = 1'b0;
    #1;
    total++;
    if (bus.nWAIT !== 1'b1) begin
      bad++;
      $display("FAIL reset_nwait: got %b want 1", bus.nWAIT);
    end
    total++;
    if (dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 0", dbg_state);
    end
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    bus.nMREQ = 1'b1;
    nRESET = 1'b1;
  endtask

  task automatic test_word_read();
    int w;
    logic [31:0] f, r;
    bus_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, w, f, r);
    total++;
    if (w != exp_waits(1'b0)) begin
      bad++;
      $display("FAIL read0_waits: got %0d want %0d", w, exp_waits(1'b0));
    end
    total++;
    if (r !== 32'h00010000) begin
      bad++;
      $display("FAIL read0_data: got %h want 00010000", r);
    end
    total++;
    if (f !== 32'h00010000) begin
      bad++;
      $display("FAIL read0_wait_cycle_data: got %h want 00010000", f);
    end
    bus_access(1'b0, 1'b0, 1'b1, 32'h10002, 32'h0, w, f, r);
    total++;
    if (r !== 32'hEA000010) begin
      bad++;
      $display("FAIL read_unaligned: got %h want EA000010", r);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] f, r;
    bus_access(1'b0, 1'b0, 1'b1, 32'h10000, 32'h0, w, f, r);
    total++;
    if (w != 1 || r !== 32'hEA000010) begin
      bad++;
      $display("FAIL nseq_read: got waits=%0d data=%h want waits=1 data=EA000010", w, r);
    end
    bus_access(1'b1, 1'b0, 1'b1, 32'h10004, 32'h0, w, f, r);
    total++;
    if (w != 0) begin
      bad++;
      $display("FAIL seq_read_waits: got %0d want 0", w);
    end
    total++;
    if (r !== 32'h00000000) begin
      bad++;
      $display("FAIL seq_read_data: got %h want 00000000", r);
    end
  endtask

  task automatic test_write_mix();
    int w;
    logic [31:0] f, r;
    bus_access(1'b0, 1'b1, 1'b1, 32'h20, 32'h11223344, w, f, r);
    total++;
    if (w != 1) begin
      bad++;
      $display("FAIL write_waits: got %0d want 1", w);
    end
    bus_access(1'b0, 1'b1, 1'b0, 32'h21, 32'h000000AB, w, f, r);
    bus_access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, w, f, r);
    total++;
    if (r !== 32'h1122AB44) begin
      bad++;
      $display("FAIL word_after_byte: got %h want 1122AB44", r);
    end
    bus_access(1'b0, 1'b0, 1'b0, 32'h23, 32'h0, w, f, r);
    total++;
    if (r !== 32'h11111111) begin
      bad++;
      $display("FAIL byte_read: got %h want 11111111", r);
    end
  endtask

  task automatic test_idle_cycle();
    int w;
    logic [31:0] f, r;
    @(negedge MCLK);
    bus.AddressBus = 32'h20;
    bus.nRW = 1'b1;
    bus.nBW = 1'b1;
    bus.SEQ = 1'b0;
    bus.nMREQ = 1'b1;
    drv_en = 1'b1;
    drv_data = 32'hDEADBEEF;
    #1;
    total++;
    if (bus.nWAIT !== 1'b1) begin
      bad++;
      $display("FAIL idle_nwait: got %b want 1", bus.nWAIT);
    end
    total++;
    if (DataBus !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL idle_bus_undriven: got %h want DEADBEEF", DataBus);
    end
    repeat (2) @(posedge MCLK);
    #1;
    drv_en = 1'b0;
    bus_access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, w, f, r);
    total++;
    if (r !== 32'h1122AB44) begin
      bad++;
      $display("FAIL idle_no_write: got %h want 1122AB44", r);
    end
  endtask

  task automatic test_reset_mid_write();
    int w;
    logic [31:0] f, r;
    @(negedge MCLK);
    bus.AddressBus = 32'h40;
    bus.nRW = 1'b1;
    bus.nBW = 1'b1;
    bus.SEQ = 1'b0;
    bus.nMREQ = 1'b0;
    drv_en = 1'b1;
    drv_data = 32'h55667788;
    #1;
    total++;
    if (bus.nWAIT !== 1'b0) begin
      bad++;
      $display("FAIL midrst_wait_low: got %b want 0", bus.nWAIT);
    end
    nRESET = 1'b0;
    #1;
    total++;
    if (bus.nWAIT !== 1'b1) begin
      bad++;
      $display("FAIL midrst_nwait: got %b want 1", bus.nWAIT);
    end
    @(posedge MCLK);
    @(negedge MCLK);
    bus.nMREQ = 1'b1;
    drv_en = 1'b0;
    nRESET = 1'b1;
    bus_access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, w, f, r);
    total++;
    if (r !== model_read(1'b1, 32'h40) || w != exp_waits(1'b0)) begin
      bad++;
      $display("FAIL midrst_after: got data=%h waits=%0d want data=%h waits=%0d",
               r, w, model_read(1'b1, 32'h40), exp_waits(1'b0));
    end
  endtask

  task automatic test_random();
    int w;
    logic [31:0] f, r, addr, wd, exp;
    logic seq, rw, bw;
    for (int i = 0; i < 60; i++) begin
      seq  = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      bw   = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFE0000) | (32'h200 + 32'($urandom_range(0, 31)));
      wd   = $urandom;
      exp  = model_read(bw, addr);
      bus_access(seq, rw, bw, addr, wd, w, f, r);
      total++;
      if (w != exp_waits(seq)) begin
        bad++;
        $display("FAIL rand_waits[%0d]: got %0d want %0d", i, w, exp_waits(seq));
      end
      if (!rw) begin
        total++;
        if (r !== exp) begin
          bad++;
          $display("FAIL rand_read[%0d] addr=%h bw=%b: got %h want %h", i, addr, bw, r, exp);
        end
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    drv_en = 1'b0;
    drv_data = 32'h0;
    nRESET = 1'b0;
    bus.nMREQ = 1'b1;
    bus.nRW = 1'b0;
    bus.nBW = 1'b1;
    bus.SEQ = 1'b0;
    bus.AddressBus = 32'h0;
    for (int i = 0; i < MEM_SIZE; i++) dut.Memory[i] = 8'h00;
    preload(0, 8'h00);
    preload(1, 8'h00);
    preload(2, 8'h01);
    preload(3, 8'h00);
    preload(32'h10000, 8'h10);
    preload(32'h10001, 8'h00);
    preload(32'h10002, 8'h00);
    preload(32'h10003, 8'hEA);

    test_reset();
    test_word_read();
    test_back_to_back();
    test_write_mix();
    test_idle_cycle();
    test_reset_mid_write();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
